// File: rtl/mips_mem_ctrl_if.sv
// Core-side bus of the unified memory controller: instruction fetch port (I),
// data load/store port (D) and the sticky fault report.
interface mips_mem_ctrl_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_rd_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic [31:0] err_addr;

  modport master (
    output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata,
    input  i_rdata, i_ack, d_rdata, d_ack, err, err_addr
  );

  modport slave (
    input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata,
    output i_rdata, i_ack, d_rdata, d_ack, err, err_addr
  );
endinterface

// File: rtl/mips_mem_ctrl.sv
// Single-ported word memory shared by the MIPS core's I and D ports, with
// round-robin arbitration, fixed wait states and a sticky range/alignment fault.
module mips_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic            clk,
  input  logic            reset,
  mips_mem_ctrl_if.slave  bus
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_port_d;
  logic        r_last_d;
  logic        r_rd_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_i_ack;
  logic        r_d_ack;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

  logic              w_grant;
  logic              w_grant_d;
  logic              w_acc_d;
  logic              w_acc_rd;
  logic              w_access;
  logic              w_fault;
  logic [1:0]        w_lo;
  logic [31:0]       w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [31:0]       w_off;
  logic [31:0]       w_rd_val;
  logic [ADDR_W-1:0] w_idx;

  // With zero wait states the access happens on the grant edge, so the access
  // operands come straight from the bus in IDLE and from the latches otherwise.
  always_comb begin
    w_grant   = bus.i_req | bus.d_req;
    w_grant_d = bus.d_req & (~bus.i_req | ~r_last_d);
    if (r_state == S_IDLE) begin
      w_acc_d     = w_grant_d;
      w_acc_rd    = w_grant_d ? bus.d_rd_wr : 1'b1;
      w_acc_addr  = w_grant_d ? bus.d_addr : bus.i_addr;
      w_acc_wdata = bus.d_wdata;
    end else begin
      w_acc_d     = r_port_d;
      w_acc_rd    = r_rd_wr;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_access = reset & (((r_state == S_IDLE) && w_grant && (WC == 4'd0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1)));
    w_off    = w_acc_addr - BASE_ADDR;
    w_lo     = w_off[1:0] + BASE_ADDR[1:0];
    w_fault  = (w_lo != 2'b00) || (w_off[31:ADDR_W+2] != '0);
    w_idx    = w_off[ADDR_W+1:2];
    if (!w_acc_rd)
      w_rd_val = '0;
    else if (w_fault)
      w_rd_val = ERR_DATA;
    else
      w_rd_val = r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (w_access && !w_fault && !w_acc_rd)
      r_mem[w_idx] <= w_acc_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_port_d   <= 1'b0;
      r_last_d   <= 1'b0;
      r_rd_wr    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_port_d <= w_grant_d;
            r_last_d <= w_grant_d;
            r_rd_wr  <= w_acc_rd;
            r_addr   <= w_acc_addr;
            r_wdata  <= bus.d_wdata;
            r_cnt    <= WC;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT:  r_cnt   <= r_cnt - 4'd1;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Access overrides the IDLE/WAIT transition above so it lands in RESP.
      if (w_access) begin
        r_state <= S_RESP;
        if (w_fault) begin
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= w_acc_addr;
        end
        if (w_acc_d) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= w_rd_val;
        end else begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= w_rd_val;
        end
      end
    end
  end

  assign bus.i_ack    = r_i_ack;
  assign bus.d_ack    = r_d_ack;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.err      = r_err;
  assign bus.err_addr = r_err_addr;
endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Scoreboard bench for mips_mem_ctrl: two instances (2 and 0 wait states)
// share one stimulus set; a negedge monitor pops expected responses on each ack.
module tb_mips_mem_ctrl;
  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
    logic [31:0] eaddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel0;
  logic        tb_i_req, tb_d_req, tb_rd_wr;
  logic [31:0] tb_i_addr, tb_d_addr, tb_wdata;

  logic        m_i_ack, m_d_ack, m_err;
  logic [31:0] m_i_rdata, m_d_rdata, m_err_addr;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  logic        model_err;
  logic [31:0] model_eaddr;

  mips_mem_ctrl_if bus2 ();
  mips_mem_ctrl_if bus0 ();

  assign bus2.i_req   = tb_i_req & ~sel0;
  assign bus2.d_req   = tb_d_req & ~sel0;
  assign bus2.i_addr  = tb_i_addr;
  assign bus2.d_addr  = tb_d_addr;
  assign bus2.d_rd_wr = tb_rd_wr;
  assign bus2.d_wdata = tb_wdata;
  assign bus0.i_req   = tb_i_req & sel0;
  assign bus0.d_req   = tb_d_req & sel0;
  assign bus0.i_addr  = tb_i_addr;
  assign bus0.d_addr  = tb_d_addr;
  assign bus0.d_rd_wr = tb_rd_wr;
  assign bus0.d_wdata = tb_wdata;

  assign m_i_ack    = sel0 ? bus0.i_ack    : bus2.i_ack;
  assign m_d_ack    = sel0 ? bus0.d_ack    : bus2.d_ack;
  assign m_i_rdata  = sel0 ? bus0.i_rdata  : bus2.i_rdata;
  assign m_d_rdata  = sel0 ? bus0.d_rdata  : bus2.d_rdata;
  assign m_err      = sel0 ? bus0.err      : bus2.err;
  assign m_err_addr = sel0 ? bus0.err_addr : bus2.err_addr;

  mips_mem_ctrl #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .reset(reset_n), .bus(bus2));
  mips_mem_ctrl #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (m_i_ack || m_d_ack) begin
        exp_t e;
        ack_cnt++;
        ack_cyc = cyc;
        chk("single_ack", {31'b0, m_i_ack & m_d_ack}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: ack seen at cycle %0d, required none", cyc);
        end else begin
          e = q.pop_front();
          chk("ack_port", {31'b0, m_d_ack}, {31'b0, e.is_d});
          chk("rdata", m_d_ack ? m_d_rdata : m_i_rdata, e.data);
          chk("err", {31'b0, m_err}, {31'b0, e.err});
          chk("err_addr", m_err_addr, e.eaddr);
        end
      end else begin
        chk("rdata_idle", m_i_rdata | m_d_rdata, 32'd0);
      end
    end
  end

  task automatic wait_ack(input int n0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk); #1;
      if (ack_cnt != n0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL ack_timeout: no ack within 40 cycles, required one");
    end
  endtask

  function automatic void push_exp(input bit is_d, input bit rd, input logic [31:0] addr,
                                   input logic [31:0] rexp);
    exp_t        e;
    logic [31:0] off;
    bit          flt;
    off = addr - BASE;
    flt = (addr[1:0] != 2'b00) || (off >= 32'h0020_0000);
    if (flt) begin
      if (!model_err) model_eaddr = addr;
      model_err = 1'b1;
    end
    e.is_d  = is_d;
    e.data  = !rd ? 32'd0 : (flt ? ERRD : rexp);
    e.err   = model_err;
    e.eaddr = model_eaddr;
    q.push_back(e);
  endfunction

  task automatic txn(input bit is_d, input bit rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rexp);
    int start, n0;
    bit ok;
    push_exp(is_d, rd, addr, rexp);
    @(posedge clk); #1;
    start = cyc;
    n0    = ack_cnt;
    if (is_d) begin
      tb_d_req = 1'b1; tb_rd_wr = rd; tb_d_addr = addr; tb_wdata = wdata;
    end else begin
      tb_i_req = 1'b1; tb_i_addr = addr;
    end
    wait_ack(n0, ok);
    tb_i_req = 1'b0;
    tb_d_req = 1'b0;
    if (ok) chk("latency", ack_cyc - start, sel0 ? 32'd1 : 32'd3);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    model_err   = 1'b0;
    model_eaddr = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int  prev, n;
    bit  ok;
    reset_n = 1'b0; sel0 = 1'b0;
    tb_i_req = 1'b0; tb_d_req = 1'b0; tb_rd_wr = 1'b0;
    tb_i_addr = '0; tb_d_addr = '0; tb_wdata = '0;
    model_err = 1'b0; model_eaddr = '0;
    #12;
    chk("rst_acks", {30'b0, m_i_ack, m_d_ack}, 32'd0);
    chk("rst_rdata", m_i_rdata | m_d_rdata, 32'd0);
    chk("rst_err", {31'b0, m_err}, 32'd0);
    chk("rst_err_addr", m_err_addr, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: write then read back
    txn(1'b1, 1'b0, 32'h8002_0010, 32'h1234_5678, 32'h0);
    txn(1'b1, 1'b1, 32'h8002_0010, 32'h0, 32'h1234_5678);

    // 2: simultaneous held requests after reset alternate D, I, D, I
    do_reset();
    for (int k = 0; k < 4; k++) push_exp(k % 2 == 0, 1'b1, 32'h8002_0010, 32'h1234_5678);
    @(posedge clk); #1;
    tb_i_addr = 32'h8002_0010; tb_d_addr = 32'h8002_0010; tb_rd_wr = 1'b1;
    tb_i_req = 1'b1; tb_d_req = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = ack_cnt;
      wait_ack(n, ok);
      if (ok && k > 0) chk("rr_gap", ack_cyc - prev, 32'd4);
      prev = ack_cyc;
    end
    tb_i_req = 1'b0; tb_d_req = 1'b0;

    // 3: out-of-range and misaligned faults
    txn(1'b1, 1'b1, 32'h7FFF_FFFC, 32'h0, 32'h0);
    txn(1'b0, 1'b1, 32'h8002_0002, 32'h0, 32'h0);

    // 4: top word of the window, then one past it (aliases word 0 if unchecked)
    txn(1'b1, 1'b0, 32'h8002_0000, 32'h1111_0000, 32'h0);
    txn(1'b1, 1'b0, 32'h8021_FFFC, 32'hA5A5_A5A5, 32'h0);
    txn(1'b1, 1'b1, 32'h8021_FFFC, 32'h0, 32'hA5A5_A5A5);
    txn(1'b1, 1'b0, 32'h8022_0000, 32'hBAD0_BAD0, 32'h0);
    txn(1'b1, 1'b1, 32'h8002_0000, 32'h0, 32'h1111_0000);

    // 5: reset during WAIT of a write aborts it
    txn(1'b1, 1'b0, 32'h8002_0020, 32'h0, 32'h0);
    @(posedge clk); #1;
    tb_d_req = 1'b1; tb_rd_wr = 1'b0; tb_d_addr = 32'h8002_0020; tb_wdata = 32'h55AA_55AA;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_acks", {30'b0, m_i_ack, m_d_ack}, 32'd0);
    chk("abort_rdata", m_i_rdata | m_d_rdata, 32'd0);
    chk("abort_err", {31'b0, m_err}, 32'd0);
    chk("abort_err_addr", m_err_addr, 32'd0);
    tb_d_req = 1'b0;
    model_err = 1'b0; model_eaddr = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    txn(1'b1, 1'b1, 32'h8002_0020, 32'h0, 32'h0);

    // 6: zero wait states, held I request walks three words
    sel0 = 1'b1;
    txn(1'b1, 1'b0, 32'h8002_0000, 32'hCAFE_0000, 32'h0);
    txn(1'b1, 1'b0, 32'h8002_0004, 32'hCAFE_0004, 32'h0);
    txn(1'b1, 1'b0, 32'h8002_0008, 32'hCAFE_0008, 32'h0);
    for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b1, 32'h8002_0000 + 32'(4 * k), 32'hCAFE_0000 + 32'(4 * k));
    @(posedge clk); #1;
    tb_i_addr = 32'h8002_0000;
    tb_i_req  = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = ack_cnt;
      wait_ack(n, ok);
      if (ok && k > 0) chk("i_gap", ack_cyc - prev, 32'd2);
      prev = ack_cyc;
      tb_i_addr = tb_i_addr + 32'd4;
    end
    tb_i_req = 1'b0;
    repeat (4) @(posedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
